// File: rtl/axil_cmd_master_if.sv
// Bus bundle for axil_cmd_master: command/response request port plus the AXI4-Lite master channels.
// The master modport is the bridge view; the slave modport is the requester/peripheral side.
interface axil_cmd_master_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_SIZE = 8
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_write;
  logic [ADDRESS_SIZE-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]     cmd_wdata;
  logic [DATA_WIDTH/8-1:0]   cmd_wstrb;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_WIDTH-1:0]     rsp_rdata;
  logic [1:0]                rsp_resp;

  logic [ADDRESS_SIZE-1:0]   AWADDR;
  logic                      AWVALID;
  logic                      AWREADY;
  logic [DATA_WIDTH-1:0]     WDATA;
  logic [DATA_WIDTH/8-1:0]   WSTRB;
  logic                      WVALID;
  logic                      WREADY;
  logic [1:0]                BRESP;
  logic                      BVALID;
  logic                      BREADY;
  logic [ADDRESS_SIZE-1:0]   ARADDR;
  logic                      ARVALID;
  logic                      ARREADY;
  logic [DATA_WIDTH-1:0]     RDATA;
  logic [1:0]                RRESP;
  logic                      RVALID;
  logic                      RREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_resp,
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp,
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY
  );
endinterface

// File: rtl/axil_cmd_master.sv
// AXI4-Lite master bridge: one command in, one complete AXI-Lite transaction, one response out.
// All bus-facing outputs come straight from flops; one transaction outstanding at a time.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// WR      | AW and W offered independently until both have handshaken
// WR_RESP | BREADY high, waiting for BVALID
// RD_ADDR | ARVALID held until ARREADY
// RD_DATA | RREADY high, waiting for RVALID
// RESP    | rsp_valid held until rsp_ready
module axil_cmd_master #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_SIZE = 8
) (
  input logic               ACLK,
  input logic               ARESETn,
  axil_cmd_master_if.master bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t state, state_n;

  logic                    cmd_ready_q, cmd_ready_n;
  logic                    rsp_valid_q, rsp_valid_n;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_n;
  logic [1:0]              rsp_resp_q, rsp_resp_n;
  logic [ADDRESS_SIZE-1:0] awaddr_q, awaddr_n;
  logic                    awvalid_q, awvalid_n;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_n;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_n;
  logic                    wvalid_q, wvalid_n;
  logic                    bready_q, bready_n;
  logic [ADDRESS_SIZE-1:0] araddr_q, araddr_n;
  logic                    arvalid_q, arvalid_n;
  logic                    rready_q, rready_n;
  logic                    aw_done_q, aw_done_n;
  logic                    w_done_q, w_done_n;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;

  assign aw_hs = awvalid_q & bus.AWREADY;
  assign w_hs  = wvalid_q & bus.WREADY;
  assign ar_hs = arvalid_q & bus.ARREADY;
  assign b_hs  = bready_q & bus.BVALID;
  assign r_hs  = rready_q & bus.RVALID;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      state       <= state_n;
      cmd_ready_q <= cmd_ready_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_rdata_q <= rsp_rdata_n;
      rsp_resp_q  <= rsp_resp_n;
      awaddr_q    <= awaddr_n;
      awvalid_q   <= awvalid_n;
      wdata_q     <= wdata_n;
      wstrb_q     <= wstrb_n;
      wvalid_q    <= wvalid_n;
      bready_q    <= bready_n;
      araddr_q    <= araddr_n;
      arvalid_q   <= arvalid_n;
      rready_q    <= rready_n;
      aw_done_q   <= aw_done_n;
      w_done_q    <= w_done_n;
    end
  end

  always_comb begin
    state_n     = state;
    rsp_valid_n = rsp_valid_q;
    rsp_rdata_n = rsp_rdata_q;
    rsp_resp_n  = rsp_resp_q;
    awaddr_n    = awaddr_q;
    awvalid_n   = awvalid_q;
    wdata_n     = wdata_q;
    wstrb_n     = wstrb_q;
    wvalid_n    = wvalid_q;
    bready_n    = bready_q;
    araddr_n    = araddr_q;
    arvalid_n   = arvalid_q;
    rready_n    = rready_q;
    aw_done_n   = aw_done_q;
    w_done_n    = w_done_q;

    case (state)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          if (bus.cmd_write) begin
            awaddr_n  = bus.cmd_addr;
            wdata_n   = bus.cmd_wdata;
            wstrb_n   = bus.cmd_wstrb;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            aw_done_n = 1'b0;
            w_done_n  = 1'b0;
            state_n   = WR;
          end else begin
            araddr_n  = bus.cmd_addr;
            arvalid_n = 1'b1;
            state_n   = RD_ADDR;
          end
        end
      end
      WR: begin
        // AW and W retire independently; leave only once both have completed.
        if (aw_hs) begin
          awvalid_n = 1'b0;
          aw_done_n = 1'b1;
        end
        if (w_hs) begin
          wvalid_n = 1'b0;
          w_done_n = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          bready_n = 1'b1;
          state_n  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          bready_n    = 1'b0;
          rsp_resp_n  = bus.BRESP;
          rsp_rdata_n = '0;
          rsp_valid_n = 1'b1;
          state_n     = RESP;
        end
      end
      RD_ADDR: begin
        if (ar_hs) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (r_hs) begin
          rready_n    = 1'b0;
          rsp_rdata_n = bus.RDATA;
          rsp_resp_n  = bus.RRESP;
          rsp_valid_n = 1'b1;
          state_n     = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Registered so it stays low through reset and rises on the first clock after release.
    cmd_ready_n = (state_n == IDLE);
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_resp  = rsp_resp_q;
  assign bus.AWADDR    = awaddr_q;
  assign bus.AWVALID   = awvalid_q;
  assign bus.WDATA     = wdata_q;
  assign bus.WSTRB     = wstrb_q;
  assign bus.WVALID    = wvalid_q;
  assign bus.BREADY    = bready_q;
  assign bus.ARADDR    = araddr_q;
  assign bus.ARVALID   = arvalid_q;
  assign bus.RREADY    = rready_q;
endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: a cycle-stepped requester and AXI-Lite slave with a word-memory
// reference; responses are predicted from the command stream, handshake timing from the latency rules.
module tb_axil_cmd_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axil_cmd_master_if #(.DATA_WIDTH(32), .ADDRESS_SIZE(8)) bus ();
  axil_cmd_master #(.DATA_WIDTH(32), .ADDRESS_SIZE(8)) dut (
    .ACLK(clk), .ARESETn(rst_n), .bus(bus)
  );

  typedef struct {
    bit          write;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  resp;
    int          lat_aw, lat_w, lat_b, lat_ar, lat_r, lat_rsp;
  } cmd_t;

  cmd_t        cmd_q[$];
  logic [31:0] slave_mem [256];
  logic [31:0] ref_mem   [256];
  int total = 0;
  int bad = 0;
  int lat_aw_obs, lat_w_obs, lat_ar_obs, lat_rsp_obs, rsp_cycles, rsp_count;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  task automatic push_cmd(input bit write, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [1:0] resp, input int l_aw,
                          input int l_w, input int l_b, input int l_ar, input int l_r,
                          input int l_rsp);
    cmd_t c;
    c.write = write; c.addr = addr; c.wdata = wdata; c.wstrb = wstrb; c.resp = resp;
    c.lat_aw = l_aw; c.lat_w = l_w; c.lat_b = l_b; c.lat_ar = l_ar; c.lat_r = l_r;
    c.lat_rsp = l_rsp;
    cmd_q.push_back(c);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {bus.cmd_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_resp, bus.AWADDR,
              bus.AWVALID, bus.WDATA, bus.WSTRB, bus.WVALID, bus.BREADY, bus.ARADDR,
              bus.ARVALID, bus.RREADY}, 128'd0);
  endtask

  task automatic clear_slave();
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0;
    bus.cmd_wstrb = 0; bus.rsp_ready = 0; bus.AWREADY = 0; bus.WREADY = 0;
    bus.BRESP = 0; bus.BVALID = 0; bus.ARREADY = 0; bus.RDATA = 0; bus.RRESP = 0;
    bus.RVALID = 0;
  endtask

  // Steps the requester and slave one cycle per falling edge until the queue drains.
  task automatic run_cmds(input bit hold, input bit abort_b, input int budget);
    int n = 0, acc = 0;
    bit infl = 0;
    cmd_t cur;
    logic [31:0] exp_rdata = 0;
    bit aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0;
    bit aw_seen = 0, w_seen = 0, ar_seen = 0, b_on = 0, r_on = 0, rsp_seen = 0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0, rsp_cnt = 0;
    logic [7:0] aw_obs = 0, ar_obs = 0;
    logic [31:0] wd_obs = 0;
    logic [3:0] ws_obs = 0;
    while ((cmd_q.size() != 0 || infl) && n < budget) begin
      @(negedge clk);
      n++;
      bus.AWREADY = 0; bus.WREADY = 0; bus.ARREADY = 0; bus.rsp_ready = 0;
      if (cmd_q.size() != 0 && (hold || !infl)) begin
        bus.cmd_valid = 1; bus.cmd_write = cmd_q[0].write; bus.cmd_addr = cmd_q[0].addr;
        bus.cmd_wdata = cmd_q[0].wdata; bus.cmd_wstrb = cmd_q[0].wstrb;
      end else bus.cmd_valid = 0;
      if (bus.cmd_ready) chk("cmd_ready_only_idle", infl, 0);
      if (!infl) chk("rsp_valid_idle", bus.rsp_valid, 0);
      if (bus.cmd_valid && bus.cmd_ready) begin
        cur = cmd_q.pop_front();
        infl = 1; acc = n;
        aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
        aw_seen = 0; w_seen = 0; ar_seen = 0; b_on = 0; r_on = 0; rsp_seen = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0; rsp_cnt = 0;
        exp_rdata = cur.write ? 32'd0 : ref_mem[cur.addr];
        rsp_cycles = 0;
      end else if (infl) begin
        if (abort_b && bus.BREADY) return;
        if (cur.write) begin
          chk("no_ar_on_write", bus.ARVALID, 0);
          if (bus.BREADY) chk("bready_after_aw_w", {aw_hs, w_hs}, 2'b11);
          if (b_hs) begin
            bus.BVALID = 0; bus.BRESP = 0;
          end else if (aw_hs && w_hs) begin
            if (!b_on) begin
              if (b_cnt >= cur.lat_b) begin
                bus.BVALID = 1; bus.BRESP = cur.resp; b_on = 1;
                slave_mem[aw_obs] = merge(slave_mem[aw_obs], wd_obs, ws_obs);
              end else b_cnt++;
            end
            if (b_on && bus.BREADY) b_hs = 1;
          end
          if (aw_hs) chk("awvalid_drop", bus.AWVALID, 0);
          else if (bus.AWVALID) begin
            chk("awaddr", bus.AWADDR, cur.addr);
            aw_seen = 1;
            if (aw_cnt >= cur.lat_aw) begin
              bus.AWREADY = 1; aw_hs = 1; aw_obs = bus.AWADDR; lat_aw_obs = n - acc;
            end else aw_cnt++;
          end else chk("awvalid_held", aw_seen, 0);
          if (w_hs) chk("wvalid_drop", bus.WVALID, 0);
          else if (bus.WVALID) begin
            chk("wdata", {bus.WDATA, bus.WSTRB}, {cur.wdata, cur.wstrb});
            w_seen = 1;
            if (w_cnt >= cur.lat_w) begin
              bus.WREADY = 1; w_hs = 1; wd_obs = bus.WDATA; ws_obs = bus.WSTRB;
              lat_w_obs = n - acc;
            end else w_cnt++;
          end else chk("wvalid_held", w_seen, 0);
        end else begin
          chk("no_aw_w_on_read", {bus.AWVALID, bus.WVALID}, 2'b00);
          if (bus.RREADY) chk("rready_after_ar", ar_hs, 1);
          if (r_hs) begin
            bus.RVALID = 0; bus.RRESP = 0;
          end else if (ar_hs) begin
            if (!r_on) begin
              if (r_cnt >= cur.lat_r) begin
                bus.RVALID = 1; bus.RDATA = slave_mem[ar_obs]; bus.RRESP = cur.resp; r_on = 1;
              end else r_cnt++;
            end
            if (r_on && bus.RREADY) r_hs = 1;
          end
          if (ar_hs) chk("arvalid_drop", bus.ARVALID, 0);
          else if (bus.ARVALID) begin
            chk("araddr", bus.ARADDR, cur.addr);
            ar_seen = 1;
            if (ar_cnt >= cur.lat_ar) begin
              bus.ARREADY = 1; ar_hs = 1; ar_obs = bus.ARADDR; lat_ar_obs = n - acc;
            end else ar_cnt++;
          end else chk("arvalid_held", ar_seen, 0);
        end
        if (bus.rsp_valid) begin
          chk("rsp_after_bus_done", cur.write ? b_hs : r_hs, 1);
          chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
          chk("rsp_resp", bus.rsp_resp, cur.resp);
          chk("cmd_ready_busy", bus.cmd_ready, 0);
          if (!rsp_seen) begin
            rsp_seen = 1; lat_rsp_obs = n - acc;
          end
          rsp_cycles++;
          if (rsp_cnt >= cur.lat_rsp) begin
            bus.rsp_ready = 1; infl = 0; rsp_count++;
            if (cur.write) ref_mem[cur.addr] = merge(ref_mem[cur.addr], cur.wdata, cur.wstrb);
          end else rsp_cnt++;
        end
      end
    end
    chk("queue_drained", {cmd_q.size() == 0, infl}, 2'b10);
  endtask

  initial begin
    logic [31:0] v;
    clear_slave();
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      slave_mem[i] = v;
      ref_mem[i] = v;
    end
    slave_mem[8] = 32'h1234_5678;
    ref_mem[8] = 32'h1234_5678;
    rsp_count = 0;

    #3 chk_zero("reset_outputs");
    @(negedge clk); #2 rst_n = 1;
    @(negedge clk);
    chk("cmd_ready_after_reset", bus.cmd_ready, 1);

    push_cmd(1, 8'h04, 32'h0000_00A5, 4'hF, 2'b00, 0, 0, 0, 0, 0, 0);
    run_cmds(0, 0, 100);
    chk("t1_aw_latency", lat_aw_obs, 1);
    chk("t1_w_latency", lat_w_obs, 1);
    chk("t1_rsp_latency", lat_rsp_obs, 3);

    push_cmd(0, 8'h08, 32'h0, 4'h0, 2'b00, 0, 0, 0, 0, 3, 0);
    run_cmds(0, 0, 100);
    chk("t2_ar_latency", lat_ar_obs, 1);
    chk("t2_rsp_latency", lat_rsp_obs, 6);

    push_cmd(1, 8'h10, 32'hDEAD_BEEF, 4'b0101, 2'b00, 2, 0, 1, 0, 0, 0);
    run_cmds(0, 0, 100);
    chk("t3a_aw_latency", lat_aw_obs, 3);
    chk("t3a_w_latency", lat_w_obs, 1);
    push_cmd(1, 8'h10, 32'hCAFE_F00D, 4'b1010, 2'b01, 0, 2, 0, 0, 0, 0);
    run_cmds(0, 0, 100);
    chk("t3b_aw_latency", lat_aw_obs, 1);
    chk("t3b_w_latency", lat_w_obs, 3);
    push_cmd(0, 8'h10, 32'h0, 4'h0, 2'b00, 0, 0, 0, 1, 1, 0);
    run_cmds(0, 0, 100);

    push_cmd(0, 8'h08, 32'h0, 4'h0, 2'b10, 0, 0, 0, 0, 0, 4);
    run_cmds(0, 0, 100);
    chk("t4_rsp_hold_cycles", rsp_cycles, 5);

    push_cmd(1, 8'h20, 32'h5555_AAAA, 4'hF, 2'b00, 0, 0, 5, 0, 0, 0);
    run_cmds(0, 1, 100);
    chk("t5_reached_wr_resp", bus.BREADY, 1);
    #2 rst_n = 0;
    #1 chk_zero("t5_async_reset");
    clear_slave();
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("t5_cmd_ready_after_release", bus.cmd_ready, 1);
    push_cmd(0, 8'h20, 32'h0, 4'h0, 2'b11, 0, 0, 0, 0, 0, 0);
    run_cmds(0, 0, 100);

    rsp_count = 0;
    push_cmd(0, 8'h04, 32'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0);
    push_cmd(1, 8'h04, 32'h0BAD_C0DE, 4'b0011, 2'b00, 0, 0, 0, 0, 0, 0);
    push_cmd(0, 8'h04, 32'h0, 4'h0, 2'b01, 0, 0, 0, 0, 0, 0);
    run_cmds(1, 0, 200);
    chk("t6_response_count", rsp_count, 3);

    for (int batch = 0; batch < 2; batch++) begin
      rsp_count = 0;
      for (int k = 0; k < 20; k++)
        push_cmd($urandom_range(0, 1) == 1, 8'($urandom_range(0, 7)), $urandom,
                 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      run_cmds(batch == 1, 0, 2000);
      chk("rand_response_count", rsp_count, 20);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
